// File: rtl/multi_phase_pkg.sv
// Shared definitions for the multi-channel zero-crossing phase estimator.
// Holds the controller state encoding and the helpers that map a linear
// pair index k onto its channel pair (i, j), i < j, in lexicographic order.
package multi_phase_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_COMPUTE = 2'd2
  } state_t;

  // Number of unordered channel pairs for n channels.
  function automatic int npair(input int n);
    return n * (n - 1) / 2;
  endfunction

  // First channel of pair k: (0,1),(0,2),...,(0,n-1),(1,2),...
  function automatic int pair_i(input int k, input int n);
    int idx;
    pair_i = 0;
    idx    = 0;
    for (int i = 0; i < n - 1; i++) begin
      for (int j = i + 1; j < n; j++) begin
        if (idx == k) pair_i = i;
        idx++;
      end
    end
  endfunction

  // Second channel of pair k.
  function automatic int pair_j(input int k, input int n);
    int idx;
    pair_j = 0;
    idx    = 0;
    for (int i = 0; i < n - 1; i++) begin
      for (int j = i + 1; j < n; j++) begin
        if (idx == k) pair_j = j;
        idx++;
      end
    end
  endfunction

endpackage

// File: rtl/multi_phase_zc_detect.sv
// Per-channel rising zero-crossing detector.
// Ports:
//   clock, reset     system clock, asynchronous active-low reset
//   clear            restart the channel for a new window
//   enable           sample strobe (already gated by the controller)
//   sample           signed channel sample
//   counter          sample index to stamp (count after this strobe)
//   captured         a crossing has been timestamped this window
//   ts               timestamp of the first armed rising crossing
module zc_detect #(
  parameter int DW   = 16,
  parameter int TSW  = 16,
  parameter int HYST = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 enable,
  input  logic signed [DW-1:0] sample,
  input  logic [TSW-1:0]       counter,
  output logic                 captured,
  output logic [TSW-1:0]       ts
);

  logic signed [DW-1:0] prev;
  logic                 prev_valid;
  logic                 armed;
  logic                 crossing;

  // Arming is based on earlier samples only, so a single sample can never
  // both arm the channel and count as the crossing.
  assign crossing = prev_valid && armed && prev[DW-1] && !sample[DW-1];

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev       <= '0;
      prev_valid <= 1'b0;
      armed      <= 1'b0;
      captured   <= 1'b0;
      ts         <= '0;
    end else if (clear) begin
      prev       <= '0;
      prev_valid <= 1'b0;
      armed      <= 1'b0;
      captured   <= 1'b0;
      ts         <= '0;
    end else if (enable && !captured) begin
      prev       <= sample;
      prev_valid <= 1'b1;
      if (int'(sample) < -HYST) armed <= 1'b1;
      if (crossing) begin
        ts       <= counter;
        captured <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/multi_phase_zc.sv
// Multi-channel phase-difference estimator.
// Timestamps the first rising zero-crossing of every channel inside a
// measurement window and publishes all pairwise timestamp differences
// (ts[j] - ts[i], i < j) as one atomic update.
// Ports:
//   clock, reset   system clock, asynchronous active-low reset
//   enable         one-clock sample strobe, all channels together
//   start          begin a measurement window (ignored while busy)
//   rx             N_CH signed samples, channel c at [c*DW +: DW]
//   diff_phase     signed pair differences, pair k at [k*TSW +: TSW]
//   valid          one-clock pulse when diff_phase updates
//   timeout        one-clock pulse when a window ends incomplete
//   busy           window or computation in progress
module multi_phase_zc
  import multi_phase_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int DW      = 16,
  parameter int TSW     = 16,
  parameter int TIMEOUT = 64,
  parameter int HYST    = 0
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               enable,
  input  logic                               start,
  input  logic [N_CH*DW-1:0]                 rx,
  output logic [N_CH*(N_CH-1)/2*TSW-1:0]     diff_phase,
  output logic                               valid,
  output logic                               timeout,
  output logic                               busy
);

  localparam int NPAIR = npair(N_CH);
  localparam int CW    = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int PW    = (NPAIR > 0) ? $clog2(NPAIR + 1) : 1;

  state_t                state, state_d;
  logic [TSW-1:0]        cnt;
  logic [TSW-1:0]        cnt_next;
  logic [PW-1:0]         pidx;
  logic [N_CH-1:0]       cap;
  logic [TSW-1:0]        ts [N_CH];
  logic [TSW-1:0]        shadow [NPAIR];
  logic [TSW-1:0]        pair_diff;
  logic [CW-1:0]         sel_i, sel_j;
  logic                  all_cap, window_open, ch_en;
  logic                  clr, pair_wr, copy, fire_to;

  assign cnt_next    = cnt + TSW'(1);
  assign all_cap     = &cap;
  // Once TIMEOUT samples are taken, further strobes must not reach the
  // channels: the window is already decided on the following clock.
  assign window_open = (state == ST_ARMED) && (cnt < TSW'(TIMEOUT));
  assign ch_en       = enable && window_open;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    zc_detect #(
      .DW   (DW),
      .TSW  (TSW),
      .HYST (HYST)
    ) u_zc (
      .clock    (clock),
      .reset    (reset),
      .clear    (clr),
      .enable   (ch_en),
      .sample   (rx[c*DW +: DW]),
      .counter  (cnt_next),
      .captured (cap[c]),
      .ts       (ts[c])
    );
  end

  // One shared subtractor, stepped through the pairs by pidx.
  always_comb begin
    sel_i     = CW'(pair_i(int'(pidx), N_CH));
    sel_j     = CW'(pair_j(int'(pidx), N_CH));
    pair_diff = ts[sel_j] - ts[sel_i];
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d = state;
    clr     = 1'b0;
    pair_wr = 1'b0;
    copy    = 1'b0;
    fire_to = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          clr     = 1'b1;
          state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        // Registered capture flags already include a capture made on the
        // final strobe, so a simultaneous capture beats the timeout.
        if (all_cap) begin
          pair_wr = 1'b1;
          state_d = ST_COMPUTE;
        end else if (cnt >= TSW'(TIMEOUT)) begin
          fire_to = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_COMPUTE: begin
        if (pidx == PW'(NPAIR)) begin
          copy    = 1'b1;
          state_d = ST_IDLE;
        end else begin
          pair_wr = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: the shadow array is small and reset with everything else so the
  // published result never depends on power-up contents.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      pidx       <= '0;
      busy       <= 1'b0;
      valid      <= 1'b0;
      timeout    <= 1'b0;
      diff_phase <= '0;
      for (int k = 0; k < NPAIR; k++) shadow[k] <= '0;
    end else begin
      state   <= state_d;
      valid   <= copy;
      timeout <= fire_to;
      if (clr) begin
        cnt  <= '0;
        pidx <= '0;
        busy <= 1'b1;
      end else begin
        if (ch_en) cnt <= cnt_next;
        if (pair_wr) begin
          shadow[pidx] <= pair_diff;
          pidx         <= pidx + PW'(1);
        end
        if (copy || fire_to) busy <= 1'b0;
      end
      if (copy) begin
        for (int k = 0; k < NPAIR; k++) diff_phase[k*TSW +: TSW] <= shadow[k];
      end
    end
  end

endmodule

// File: tb/tb_multi_phase_zc.sv
// Self-checking bench for multi_phase_zc (N_CH=4, HYST=100).
module tb_multi_phase_zc;

  localparam int N_CH    = 4;
  localparam int DW      = 16;
  localparam int TSW     = 16;
  localparam int TIMEOUT = 64;
  localparam int HYST    = 100;
  localparam int NPAIR   = 6;

  logic                    clock = 1'b0;
  logic                    reset = 1'b0;
  logic                    enable = 1'b0;
  logic                    start = 1'b0;
  logic [N_CH*DW-1:0]      rx = '0;
  logic [NPAIR*TSW-1:0]    diff_phase;
  logic                    valid, timeout, busy;

  always #5 clock = ~clock;

  multi_phase_zc #(
    .N_CH    (N_CH),
    .DW      (DW),
    .TSW     (TSW),
    .TIMEOUT (TIMEOUT),
    .HYST    (HYST)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .start      (start),
    .rx         (rx),
    .diff_phase (diff_phase),
    .valid      (valid),
    .timeout    (timeout),
    .busy       (busy)
  );

  typedef struct {
    int delay [N_CH];   // -1: channel held at +1000 for the whole window
    bit exp_to;
    int exp_d [NPAIR];
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_valid, n_to, valid_cyc, to_cyc;
  int smp [N_CH][TIMEOUT];
  int last_d [NPAIR];
  int wave [4] = '{-5000, -100, 2468, 5004};

  task automatic check(input string name, input longint actual, input longint expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Advance one clock and sample outputs 1 time unit after the edge.
  task automatic tick();
    @(posedge clock);
    cyc++;
    #1;
    if (valid)   begin n_valid++; valid_cyc = cyc; end
    if (timeout) begin n_to++;    to_cyc    = cyc; end
  endtask

  function automatic int get_d(input int k);
    logic signed [TSW-1:0] v;
    v = diff_phase[k*TSW +: TSW];
    return int'(v);
  endfunction

  function automatic logic [N_CH*DW-1:0] pack_n(input int n);
    logic [N_CH*DW-1:0] r;
    for (int c = 0; c < N_CH; c++) r[c*DW +: DW] = DW'(smp[c][n]);
    return r;
  endfunction

  // Same waveform on every channel, delayed by a per-channel number of samples.
  task automatic build_delay(input int delay [N_CH]);
    for (int c = 0; c < N_CH; c++)
      for (int n = 0; n < TIMEOUT; n++) begin
        if (delay[c] < 0)          smp[c][n] = 1000;
        else if (n - delay[c] < 0) smp[c][n] = wave[0];
        else if (n - delay[c] > 3) smp[c][n] = wave[3];
        else                       smp[c][n] = wave[n - delay[c]];
      end
  endtask

  // Reference: 1-based index of the first rising crossing preceded by some
  // earlier sample below -HYST, excluding the first sample; 0 if none.
  function automatic int model_ts(input int c);
    bit armed = 0;
    for (int n = 0; n < TIMEOUT; n++) begin
      if (n > 0 && armed && smp[c][n-1] < 0 && smp[c][n] >= 0) return n + 1;
      if (smp[c][n] < -HYST) armed = 1;
    end
    return 0;
  endfunction

  task automatic run_window(input bit exp_to, input int exp_d [NPAIR],
                            input int gap_max, input bit poke, input string tag);
    int ts [N_CH];
    int en_cyc [TIMEOUT+1];
    int tmax;
    tmax = 0;
    for (int c = 0; c < N_CH; c++) begin
      ts[c] = model_ts(c);
      if (ts[c] > tmax) tmax = ts[c];
    end
    n_valid = 0;
    n_to    = 0;
    // A strobe coinciding with start must be ignored.
    start  = 1'b1;
    enable = 1'b1;
    for (int c = 0; c < N_CH; c++) rx[c*DW +: DW] = DW'(-9000);
    tick();
    start  = 1'b0;
    enable = 1'b0;
    check({tag, "_busy_start"}, busy, 1);
    for (int n = 1; n <= TIMEOUT; n++) begin
      rx     = pack_n(n - 1);
      enable = 1'b1;
      start  = poke && (n == 5);
      tick();
      en_cyc[n] = cyc;
      enable = 1'b0;
      start  = 1'b0;
      repeat ($urandom_range(gap_max)) tick();
    end
    repeat (12) tick();
    check({tag, "_valid_n"}, n_valid, exp_to ? 0 : 1);
    check({tag, "_timeout_n"}, n_to, exp_to ? 1 : 0);
    if (!exp_to && n_valid > 0)
      check({tag, "_latency"}, valid_cyc - en_cyc[tmax], NPAIR + 1);
    if (exp_to && n_to > 0)
      check({tag, "_timeout_at"}, to_cyc - en_cyc[TIMEOUT], 1);
    for (int k = 0; k < NPAIR; k++)
      check($sformatf("%s_diff%0d", tag, k), get_d(k), exp_d[k]);
    check({tag, "_busy_end"}, busy, 0);
    last_d = exp_d;
  endtask

  vec_t vecs [8];

  initial begin
    int ts [N_CH];
    int ed [NPAIR];
    int k;
    bit eto;

    vecs[0] = '{'{0, 0, 0, 0},   1'b0, '{0, 0, 0, 0, 0, 0}};
    vecs[1] = '{'{0, 1, 2, 3},   1'b0, '{1, 2, 3, 1, 2, 1}};
    vecs[2] = '{'{2, 0, 2, 2},   1'b0, '{-2, 0, 0, 2, 2, 0}};
    vecs[3] = '{'{0, 1, 2, -1},  1'b1, '{-2, 0, 0, 2, 2, 0}};
    vecs[4] = '{'{3, 2, 1, 0},   1'b0, '{-1, -2, -3, -1, -2, -1}};
    vecs[5] = '{'{60, 0, 0, 0},  1'b0, '{-60, -60, -60, 0, 0, 0}};
    vecs[6] = '{'{61, 0, 0, 0},  1'b0, '{-61, -61, -61, 0, 0, 0}};
    vecs[7] = '{'{62, 0, 0, 0},  1'b1, '{-61, -61, -61, 0, 0, 0}};
    for (int i = 0; i < NPAIR; i++) last_d[i] = 0;

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    for (int i = 0; i < NPAIR; i++) check($sformatf("reset_diff%0d", i), get_d(i), 0);
    check("reset_valid", valid, 0);
    check("reset_timeout", timeout, 0);
    check("reset_busy", busy, 0);
    reset = 1'b1;
    tick();

    // Directed table: aligned, delayed, leading, timeout, capture-on-last
    for (int i = 0; i < 8; i++) begin
      build_delay(vecs[i].delay);
      run_window(vecs[i].exp_to, vecs[i].exp_d, 0, i == 1, $sformatf("vec%0d", i));
    end

    // Hysteresis: dither inside +/-HYST (including exactly -HYST) never arms
    build_delay('{0, 0, 0, 0});
    begin
      int seq [10] = '{-50, 50, -50, 50, -100, 50, -50, 50, -200, 300};
      for (int n = 0; n < 10; n++) smp[0][n] = seq[n];
    end
    run_window(1'b0, '{-7, -7, -7, 0, 0, 0}, 0, 1'b0, "hyst");

    // Randomized windows against the reference model
    for (int w = 0; w < 25; w++) begin
      for (int c = 0; c < N_CH; c++) begin
        int mode = int'($urandom_range(7));
        for (int n = 0; n < TIMEOUT; n++)
          smp[c][n] = (mode == 0) ? int'($urandom_range(1000))
                                  : int'($urandom_range(800)) - 400;
      end
      eto = 1'b0;
      for (int c = 0; c < N_CH; c++) begin
        ts[c] = model_ts(c);
        if (ts[c] == 0) eto = 1'b1;
      end
      k = 0;
      for (int i = 0; i < N_CH - 1; i++)
        for (int j = i + 1; j < N_CH; j++) begin
          ed[k] = eto ? last_d[k] : ts[j] - ts[i];
          k++;
        end
      run_window(eto, ed, 2, 1'($urandom_range(1)), $sformatf("rnd%0d", w));
    end

    // Reset in the middle of a window, then a clean scenario-2 window
    build_delay('{0, 1, 2, 3});
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 0; n < 10; n++) begin
      rx     = pack_n(n);
      enable = 1'b1;
      tick();
    end
    enable  = 1'b0;
    reset   = 1'b0;
    n_valid = 0;
    n_to    = 0;
    #1;
    for (int i = 0; i < NPAIR; i++) check($sformatf("midrst_diff%0d", i), get_d(i), 0);
    check("midrst_busy", busy, 0);
    repeat (3) tick();
    check("midrst_valid_n", n_valid, 0);
    check("midrst_timeout_n", n_to, 0);
    reset = 1'b1;
    tick();
    build_delay('{0, 1, 2, 3});
    run_window(1'b0, '{1, 2, 3, 1, 2, 1}, 0, 1'b0, "post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_phase_zc.md
Name: multi_phase_zc

Overview:
Parametrised phase-difference estimator for the USBL receive array; next generation of the fixed 4-channel phase block. Takes one sample per channel on each sample strobe and timestamps the first rising zero-crossing of every channel inside a measurement window. It outputs all N_CH*(N_CH-1)/2 pairwise crossing-time differences, in sample units, as one atomic update. Sits between the hydrophone sample front-end and the direction-of-arrival solver.

Parameters:
N_CH, 4, number of receive channels (2..8)
DW, 16, signed sample width
TSW, 16, timestamp and difference width (signed output)
TIMEOUT, 64, maximum samples per window; must be < 2^(TSW-1)
HYST, 0, arming threshold magnitude; a channel arms only after a sample < -HYST

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
enable  in  1  sample strobe, one clock wide; all channels sampled together
start  in  1  begin a measurement window (pulse)
rx  in  N_CH*DW  signed samples, channel c at bits [c*DW +: DW]
diff_phase  out  NPAIR*TSW  signed pair differences, pair k at [k*TSW +: TSW]
valid  out  1  one-clock pulse when diff_phase is updated
timeout  out  1  one-clock pulse when a window expires incomplete
busy  out  1  high from accepted start until valid or timeout

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; diff_phase=0, valid=0, timeout=0, busy=0; all timestamps, flags and counter cleared. Reset mid-window aborts immediately with no valid or timeout pulse.
- Pair order is lexicographic (i<j): (0,1),(0,2),...,(0,N-1),(1,2),...; for N_CH=4: k=0..5 -> (0,1),(0,2),(0,3),(1,2),(1,3),(2,3).
- diff_phase[k] = ts[j] - ts[i], computed in TSW-bit two's complement. Positive means channel j crossed later.
- States: IDLE -> ARMED -> COMPUTE -> IDLE.
- IDLE: start=1 -> clear armed/captured flags, sample counter=0, prev-valid=0, busy=1, go ARMED. An enable in the same clock as start is ignored.
- ARMED, on each enable:
  - First enable after start loads prev samples only; no crossing can be detected on it.
  - Counter increments on every enable, including the first.
  - Per uncaptured channel: armed is set when sample < -HYST.
  - Crossing is detected when armed, prev < 0 and current >= 0. It captures ts[c] = counter value after the increment for that sample, and sets captured[c].
  - Channels crossing on the same enable receive equal timestamps.
  - Captured channels ignore further samples.
- ARMED exit:
  - When all channels are captured, go COMPUTE on the next clock.
  - Otherwise, if the counter reaches TIMEOUT after an enable, pulse timeout for one clock, clear busy, go IDLE. diff_phase is left unchanged.
  - If the final capture and the TIMEOUT count occur on the same enable, capture wins and there is no timeout.
- COMPUTE:
  - One pair per clock into shadow registers, NPAIR clocks.
  - Next clock: copy shadow to diff_phase, pulse valid, clear busy, go IDLE.
  - Latency: valid is asserted NPAIR+1 clocks after the clock that captured the last crossing.
  - enable and start are ignored during COMPUTE.
- start while busy is ignored. diff_phase holds its last value between updates.

Decomposition:
- Package multi_phase_pkg: NPAIR = N_CH*(N_CH-1)/2; functions pair_i(k) and pair_j(k); state encoding constants.
- Sub-module zc_detect, one instance per channel: holds prev sample, armed and captured flags, and the timestamp register. Inputs: clear, enable, sample, counter. Outputs: captured, ts.

Test Plan:
1. N_CH=4, all channels identical sequence -5000,-100,2468,5004 on successive enables -> all crossings ts=3; valid pulses 7 clocks after the capture clock; all six diffs = 0.
2. Channels delayed 0,1,2,3 samples (same waveform) -> ts=3,4,5,6; diff_phase = {1,2,3,1,2,1} for pairs k=0..5; one valid pulse.
3. Channel 1 leads channel 0 by 2 samples, channels 2 and 3 aligned with channel 0 -> k0=-2, k1=0, k2=0, k3=+2, k4=+2, k5=0 (signed check).
4. Channel 3 held at +1000 for the whole window, others crossing -> timeout pulses once, exactly at the 64th enable; no valid; diff_phase keeps the previous values; busy falls.
5. HYST=100, channel dithers -50/+50 then drops to -200 and rises to +300 -> no capture during dither; ts equals the index of the +300 sample.
6. reset asserted low in ARMED after 10 enables, then released and start re-issued with the scenario 2 stimulus -> outputs read 0 during reset; no spurious valid or timeout; the new window produces the scenario 2 results.
